fighter_ctrl: RTL
=================

# fighter_ctrl

Parametrised per-player action controller and next generation of the player state block. It converts debounced button levels into a registered one-hot action code for the sprite renderer, a one-cycle attack request for the game referee, jump timing flags and a regenerating shield meter. Over the previous generation it adds:

- generic timing and meter widths;
- a hit input with block/hitstun resolution;
- edge-triggered attacks;
- single-clock-domain shield timing with no derived clock.

## Interface
- JUMP_CYCLES, 50_000_000 — jump airtime in clk cycles (≥2)
- PUNCH_CD_CYCLES, 16_666_666 — attack cooldown in cycles (≥1)
- HITSTUN_CYCLES, 12_500_000 — stun time after an unblocked hit (≥1)
- SHIELD_W, 4 — shield meter width
- SHIELD_MAX, 15 — full meter value (≤2^SHIELD_W−1)
- SHIELD_TICK_CYCLES, 25_000_000 — meter update period
- BLOCK_COST, 3 — meter drained by a blocked hit
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- player  in  1  player index; gives the reset facing (0 right, 1 left)
- left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn  in  1 each  button levels, synchronous to clk
- hit  in  1  one-cycle pulse from game: opponent attack connected
- shield  out  SHIELD_W  meter value
- attack_request  out  1  one-cycle attack pulse
- blocked  out  1  one-cycle pulse: hit absorbed by shield
- hurt  out  1  one-cycle pulse: hit taken, hitstun started
- jump_active, jump_active_last_half  out  1  jump running / in second half
- action  out  8  action code: [7] dir (0 right, 1 left); [6:0] one-hot HITSTUN, STANDING, PUNCHING, JUMPING, SHIELDING, CROUCHING, WALKING (bit 6 down to bit 0)

## Operation
- Reset (asynchronous) values:
  - action = {player, STANDING}
  - shield = SHIELD_MAX
  - all pulses 0, jump flags 0
  - all counters 0, attack edge register 0
- Facing, dir_next:
  - right_btn only → 0; left_btn only → 1.
  - Both or neither → hold the current value.
  - Frozen during HITSTUN.
- States: GROUND (covers STANDING, WALKING, CROUCHING, SHIELDING, PUNCHING), JUMP, STUN.
- GROUND next action, evaluated in this priority order:
  1. left or right pressed → WALKING
  2. down → CROUCHING
  3. shield_btn and shield>0 → SHIELDING
  4. up → JUMPING; load jump counter; enter JUMP
  5. attack_btn → PUNCHING
  6. otherwise → STANDING
- Attack request:
  - attack_request is issued on a rising edge of attack_btn while in GROUND with cooldown idle.
  - Issuing loads the cooldown counter with PUNCH_CD_CYCLES.
  - A held button never re-fires.
  - An edge during cooldown is dropped, not queued. The PUNCHING sprite is still shown.
- Attack edge register:
  - Updates every cycle in all states.
  - A press held through JUMP or STUN does not fire on landing.
- JUMP:
  - Lasts exactly JUMP_CYCLES cycles; action is {dir, JUMPING}.
  - Buttons are ignored except for facing; no attacks.
  - jump_active_last_half is high once elapsed ≥ JUMP_CYCLES/2 (integer division).
  - The state returns to GROUND after the final cycle.
- Hit resolution (hit=1):
  - Blocked when the current action is SHIELDING and shield>0:
    - blocked pulses;
    - shield ← max(shield−BLOCK_COST, 0);
    - state is unchanged.
  - Otherwise:
    - hurt pulses;
    - enter STUN with counter = HITSTUN_CYCLES;
    - any jump is aborted (jump flags drop next cycle).
  - A hit during STUN is ignored; no pulse and no stun restart.
- STUN:
  - action = {dir, HITSTUN}.
  - Return to GROUND when the counter expires.
- Cooldown: counts down in every state, including JUMP and STUN.
- Shield tick: a free-running counter fires one tick every SHIELD_TICK_CYCLES cycles. On a tick:
  - action SHIELDING and shield>0 → decrement by 1;
  - else shield_btn low and shield<SHIELD_MAX → increment by 1;
  - else hold.
  - Tick coincident with a blocked hit: the block cost applies and the tick is skipped.
  - Meter arithmetic saturates at 0 and SHIELD_MAX; it never wraps.

## Timing
- All outputs are registered.
- Action and pulses appear the cycle after the inputs are sampled.
- Pulses (attack_request, blocked, hurt) are high for exactly one cycle.
- The first JUMPING cycle has jump_active=1; jump_active stays high for JUMP_CYCLES cycles.
- If hit and up_btn arrive in the same cycle, the hit wins.
- If hit and an attack edge arrive in the same cycle, the hit wins and no request is issued.
- Reset assertion mid-jump or mid-stun returns immediately to the reset values.

## Test plan
- Test parameters: JUMP_CYCLES=8, PUNCH_CD_CYCLES=5, HITSTUN_CYCLES=4, SHIELD_TICK_CYCLES=3, SHIELD_MAX=15, BLOCK_COST=3.
- Reset with player=1 → action=8'b1010_0000, shield=15. Press right for 1 cycle → next action=8'b0000_0001.
- Press up for 1 cycle:
  - jump_active high for exactly 8 cycles; last_half high for the final 4;
  - an attack edge mid-jump gives no request;
  - then STANDING.
- Attack:
  - Hold attack 10 cycles → exactly one attack_request.
  - Release and re-press at cycle 3 after the request → no request.
  - Re-press at cycle 6 → second request.
- Shield and block:
  - Hold shield 9 cycles from 15 → shield=12.
  - Hit while shielding → blocked pulse, shield=9, no stun.
  - Release → shield regains 1 per 3 cycles up to 15.
- Drive shield down to 2, keep holding, then apply a hit:
  - the block pulse fires and the meter clamps to 0;
  - next cycle action leaves SHIELDING.
  - A hit now gives a hurt pulse and HITSTUN for 4 cycles.
  - A second hit inside the stun gives no pulse.
- Hit during a jump → hurt pulse; jump_active drops next cycle; HITSTUN 4 cycles; facing unchanged despite left_btn.

Source files
------------

// File: rtl/fighter_ctrl.sv
// rtl/fighter_ctrl.sv - per-player action controller: action code, attack/hit pulses, jump flags, shield meter
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_player                   player index, sets the facing loaded at reset (0 right, 1 left)
//   i_left_btn .. i_shield_btn debounced button levels, synchronous to i_clk
//   i_hit                      one-cycle pulse: opponent attack connected
//   o_shield                   shield meter value
//   o_attack_request           one-cycle attack pulse for the referee
//   o_blocked, o_hurt          one-cycle hit-resolution pulses
//   o_jump_active              jump running
//   o_jump_active_last_half    jump in its second half
//   o_action                   [7] facing, [6:0] one-hot HITSTUN..WALKING
module fighter_ctrl #(
    parameter int JUMP_CYCLES        = 50_000_000,
    parameter int PUNCH_CD_CYCLES    = 16_666_666,
    parameter int HITSTUN_CYCLES     = 12_500_000,
    parameter int SHIELD_W           = 4,
    parameter int SHIELD_MAX         = 15,
    parameter int SHIELD_TICK_CYCLES = 25_000_000,
    parameter int BLOCK_COST         = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_player,
    input  logic                i_left_btn,
    input  logic                i_right_btn,
    input  logic                i_up_btn,
    input  logic                i_down_btn,
    input  logic                i_attack_btn,
    input  logic                i_shield_btn,
    input  logic                i_hit,
    output logic [SHIELD_W-1:0] o_shield,
    output logic                o_attack_request,
    output logic                o_blocked,
    output logic                o_hurt,
    output logic                o_jump_active,
    output logic                o_jump_active_last_half,
    output logic [7:0]          o_action
);

    localparam int JW = $clog2(JUMP_CYCLES);
    localparam int CW = $clog2(PUNCH_CD_CYCLES + 1);
    localparam int HW = $clog2(HITSTUN_CYCLES + 1);
    localparam int TW = $clog2(SHIELD_TICK_CYCLES + 1);

    localparam logic [JW-1:0]       JUMP_LAST = JW'(JUMP_CYCLES - 1);
    localparam logic [JW-1:0]       JUMP_HALF = JW'(JUMP_CYCLES / 2);
    localparam logic [CW-1:0]       CD_LOAD   = CW'(PUNCH_CD_CYCLES);
    localparam logic [HW-1:0]       STUN_LOAD = HW'(HITSTUN_CYCLES);
    localparam logic [TW-1:0]       TICK_LAST = TW'(SHIELD_TICK_CYCLES - 1);
    localparam logic [SHIELD_W-1:0] SH_MAX    = SHIELD_W'(SHIELD_MAX);

    localparam logic [6:0] A_HITSTUN   = 7'b100_0000;
    localparam logic [6:0] A_STANDING  = 7'b010_0000;
    localparam logic [6:0] A_PUNCHING  = 7'b001_0000;
    localparam logic [6:0] A_JUMPING   = 7'b000_1000;
    localparam logic [6:0] A_SHIELDING = 7'b000_0100;
    localparam logic [6:0] A_CROUCHING = 7'b000_0010;
    localparam logic [6:0] A_WALKING   = 7'b000_0001;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_JUMP,
        ST_STUN
    } state_t;

    state_t               r_state;
    logic [7:0]           r_action;
    logic [SHIELD_W-1:0]  r_shield;
    logic                 r_attack_req;
    logic                 r_blocked;
    logic                 r_hurt;
    logic                 r_jump_active;
    logic                 r_last_half;
    logic [JW-1:0]        r_jump_cnt;
    logic [CW-1:0]        r_cd_cnt;
    logic [HW-1:0]        r_stun_cnt;
    logic [TW-1:0]        r_tick_cnt;
    logic                 r_attack_prev;

    state_t               w_nxt_state;
    logic [6:0]           w_nxt_act;
    logic                 w_nxt_dir;
    logic [SHIELD_W-1:0]  w_nxt_shield;
    logic                 w_nxt_jump_active;
    logic                 w_nxt_last_half;
    logic [JW-1:0]        w_nxt_jump_cnt;
    logic [CW-1:0]        w_nxt_cd;
    logic [HW-1:0]        w_nxt_stun_cnt;

    logic w_tick;
    logic w_shielding;
    logic w_shield_nz;
    logic w_hit_live;
    logic w_block;
    logic w_hurt;
    logic w_fire;

    assign w_tick      = (r_tick_cnt == TICK_LAST);
    assign w_shielding = (r_action[6:0] == A_SHIELDING);
    assign w_shield_nz = (r_shield != '0);
    // Hits landing during hitstun are discarded entirely.
    assign w_hit_live  = i_hit && (r_state != ST_STUN);
    assign w_block     = w_hit_live && w_shielding && w_shield_nz;
    assign w_hurt      = w_hit_live && !w_block;
    // A hit in the same cycle suppresses the request; held buttons never refire.
    assign w_fire      = (r_state == ST_GROUND) && i_attack_btn && !r_attack_prev
                         && (r_cd_cnt == '0) && !i_hit;

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_act         = r_action[6:0];
        w_nxt_dir         = r_action[7];
        w_nxt_jump_active = 1'b0;
        w_nxt_last_half   = 1'b0;
        w_nxt_jump_cnt    = r_jump_cnt;
        w_nxt_stun_cnt    = r_stun_cnt;
        w_nxt_cd          = (r_cd_cnt != '0) ? r_cd_cnt - CW'(1) : r_cd_cnt;
        w_nxt_shield      = r_shield;

        if (r_state != ST_STUN) begin
            if (i_right_btn && !i_left_btn) begin
                w_nxt_dir = 1'b0;
            end else if (i_left_btn && !i_right_btn) begin
                w_nxt_dir = 1'b1;
            end
        end

        case (r_state)
            ST_GROUND: begin
                if (i_left_btn || i_right_btn) begin
                    w_nxt_act = A_WALKING;
                end else if (i_down_btn) begin
                    w_nxt_act = A_CROUCHING;
                end else if (i_shield_btn && w_shield_nz) begin
                    w_nxt_act = A_SHIELDING;
                end else if (i_up_btn) begin
                    w_nxt_act         = A_JUMPING;
                    w_nxt_state       = ST_JUMP;
                    w_nxt_jump_cnt    = '0;
                    w_nxt_jump_active = 1'b1;
                end else if (i_attack_btn) begin
                    w_nxt_act = A_PUNCHING;
                end else begin
                    w_nxt_act = A_STANDING;
                end
            end
            ST_JUMP: begin
                w_nxt_act = A_JUMPING;
                if (r_jump_cnt == JUMP_LAST) begin
                    w_nxt_state = ST_GROUND;
                    w_nxt_act   = A_STANDING;
                end else begin
                    w_nxt_jump_cnt    = r_jump_cnt + JW'(1);
                    w_nxt_jump_active = 1'b1;
                    w_nxt_last_half   = (r_jump_cnt + JW'(1)) >= JUMP_HALF;
                end
            end
            ST_STUN: begin
                w_nxt_act = A_HITSTUN;
                if (r_stun_cnt <= HW'(1)) begin
                    w_nxt_state    = ST_GROUND;
                    w_nxt_act      = A_STANDING;
                    w_nxt_stun_cnt = '0;
                end else begin
                    w_nxt_stun_cnt = r_stun_cnt - HW'(1);
                end
            end
            default: begin
                w_nxt_state = ST_GROUND;
                w_nxt_act   = A_STANDING;
            end
        endcase

        // A block keeps the player shielding on the ground and cancels any jump
        // started by the same cycle's buttons.
        if (w_block) begin
            w_nxt_state       = ST_GROUND;
            w_nxt_act         = r_action[6:0];
            w_nxt_jump_active = 1'b0;
            w_nxt_last_half   = 1'b0;
        end else if (w_hurt) begin
            w_nxt_state       = ST_STUN;
            w_nxt_act         = A_HITSTUN;
            w_nxt_stun_cnt    = STUN_LOAD;
            w_nxt_jump_active = 1'b0;
            w_nxt_last_half   = 1'b0;
        end

        if (w_fire) begin
            w_nxt_cd = CD_LOAD;
        end

        // Block cost takes precedence over a coincident tick; both saturate.
        if (w_block) begin
            w_nxt_shield = (int'(r_shield) > BLOCK_COST) ? r_shield - SHIELD_W'(BLOCK_COST) : '0;
        end else if (w_tick) begin
            if (w_shielding && w_shield_nz) begin
                w_nxt_shield = r_shield - SHIELD_W'(1);
            end else if (!i_shield_btn && (r_shield < SH_MAX)) begin
                w_nxt_shield = r_shield + SHIELD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_GROUND;
            r_action      <= {i_player, A_STANDING};
            r_shield      <= SH_MAX;
            r_attack_req  <= 1'b0;
            r_blocked     <= 1'b0;
            r_hurt        <= 1'b0;
            r_jump_active <= 1'b0;
            r_last_half   <= 1'b0;
            r_jump_cnt    <= '0;
            r_cd_cnt      <= '0;
            r_stun_cnt    <= '0;
            r_tick_cnt    <= '0;
            r_attack_prev <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_action      <= {w_nxt_dir, w_nxt_act};
            r_shield      <= w_nxt_shield;
            r_attack_req  <= w_fire;
            r_blocked     <= w_block;
            r_hurt        <= w_hurt;
            r_jump_active <= w_nxt_jump_active;
            r_last_half   <= w_nxt_last_half;
            r_jump_cnt    <= w_nxt_jump_cnt;
            r_cd_cnt      <= w_nxt_cd;
            r_stun_cnt    <= w_nxt_stun_cnt;
            r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_attack_prev <= i_attack_btn;
        end
    end

    assign o_shield                = r_shield;
    assign o_attack_request        = r_attack_req;
    assign o_blocked               = r_blocked;
    assign o_hurt                  = r_hurt;
    assign o_jump_active           = r_jump_active;
    assign o_jump_active_last_half = r_last_half;
    assign o_action                = r_action;

endmodule
